// File: rtl/control_unit_mc_pkg.sv
// control_unit_mc_pkg: opcode map, spec-op codes, FSM states and control word shared by the control unit
package control_unit_mc_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0010;
    localparam logic [3:0] OP_SL   = 4'b0011;
    localparam logic [3:0] OP_SR   = 4'b0100;
    localparam logic [3:0] OP_STT  = 4'b0101;
    localparam logic [3:0] OP_STF  = 4'b0110;
    localparam logic [3:0] OP_SPEC = 4'b0111;
    localparam logic [3:0] OP_SWP  = 4'b1001;
    localparam logic [3:0] OP_STL  = 4'b1010;
    localparam logic [3:0] OP_STH  = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BLT  = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;

    localparam logic [2:0] SP_INC = 3'b000;
    localparam logic [2:0] SP_AON = 3'b001;
    localparam logic [2:0] SP_HLT = 3'b010;
    localparam logic [2:0] SP_SEG = 3'b011;
    localparam logic [2:0] SP_PKR = 3'b100;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALTED} state_t;

    typedef struct packed {
        logic [3:0] alu_func;
        logic [2:0] spec_func;
        logic [2:0] dest;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       reg_write;
        logic       swap;
        logic       jmp;
        logic       done;
    } ctrl_t;

    localparam ctrl_t NOP = '0;
endpackage

// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: fetch-side instruction stream and datapath control outputs of the control unit
interface control_unit_mc_if #(parameter int INSTR_W = 9, parameter int RSEL_W = 3);
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               flush;
    logic [3:0]         alu_func;
    logic [2:0]         alu_spec_func;
    logic [RSEL_W-1:0]  reg_write_val;
    logic               alu_src;
    logic               mem_write;
    logic               mem_read;
    logic               branch;
    logic               reg_write;
    logic               swap_ctrl;
    logic               jmp_ctrl;
    logic               done_ctrl;
    logic               pc_stall;
    logic               illegal;

    modport master (
        output instruction, instr_valid, flush,
        input  alu_func, alu_spec_func, reg_write_val, alu_src, mem_write, mem_read,
               branch, reg_write, swap_ctrl, jmp_ctrl, done_ctrl, pc_stall, illegal
    );

    modport slave (
        input  instruction, instr_valid, flush,
        output alu_func, alu_spec_func, reg_write_val, alu_src, mem_write, mem_read,
               branch, reg_write, swap_ctrl, jmp_ctrl, done_ctrl, pc_stall, illegal
    );
endinterface

// File: rtl/control_unit_mc_decoder.sv
// control_unit_mc_decoder: combinational instruction -> control word; undefined encodings give NOP plus illegal
module control_unit_mc_decoder
    import control_unit_mc_pkg::*;
#(
    parameter int INSTR_W = 9
) (
    input  logic [INSTR_W-1:0] instruction,
    output ctrl_t              word,
    output logic               illegal
);
    logic [3:0] op;
    logic [2:0] sub;
    logic [2:0] d2;

    assign op  = instruction[INSTR_W-1 -: 4];
    assign sub = instruction[2:0];
    assign d2  = {1'b0, instruction[4:3]};

    always_comb begin
        word    = NOP;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SL, OP_SR, OP_STT: begin
                word.alu_func  = op;
                word.reg_write = 1'b1;
                word.dest      = d2;
            end
            OP_LD: begin
                word.mem_read  = 1'b1;
                word.reg_write = 1'b1;
                word.dest      = d2;
            end
            OP_ST: word.mem_write = 1'b1;
            OP_STF: begin
                word.alu_func  = op;
                word.reg_write = 1'b1;
                word.dest      = sub;
            end
            OP_SPEC: begin
                if (sub == SP_HLT)
                    word.done = 1'b1;
                else if (sub inside {SP_INC, SP_AON, SP_SEG, SP_PKR}) begin
                    word.alu_func  = op;
                    word.spec_func = sub;
                    word.reg_write = 1'b1;
                    word.dest      = d2;
                end else
                    illegal = 1'b1;
            end
            OP_SWP: word.swap = 1'b1;
            OP_STL, OP_STH: begin
                word.alu_func  = op;
                word.alu_src   = 1'b1;
                word.reg_write = 1'b1;
                word.dest      = instruction[4] ? 3'b111 : 3'b001;
            end
            OP_BEQ, OP_BLT: begin
                word.alu_func = op;
                word.branch   = 1'b1;
            end
            OP_JMP: word.jmp = 1'b1;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: registered multi-cycle decode with memory wait states, sticky halt and illegal trap
module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int RSEL_W  = 3,
    parameter int MEM_LAT = 2
) (
    input logic              clock,
    input logic              reset,
    control_unit_mc_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    ctrl_t         word_q, word_n, dec_word;
    logic          stall_q, stall_n, ill_q, ill_n, dec_ill, go, is_mem;

    control_unit_mc_decoder #(.INSTR_W(INSTR_W)) u_dec (
        .instruction(bus.instruction),
        .word       (dec_word),
        .illegal    (dec_ill)
    );

    assign go     = bus.instr_valid & ~bus.flush;
    assign is_mem = dec_word.mem_read | dec_word.mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_RUN;
            cnt     <= '0;
            word_q  <= NOP;
            stall_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            word_q  <= word_n;
            stall_q <= stall_n;
            ill_q   <= ill_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_RUN: begin
                if (go && dec_word.done)
                    state_n = ST_HALTED;
                else if (go && is_mem) begin
                    cnt_n   = CW'(MEM_LAT - 1);
                    state_n = (MEM_LAT > 1) ? ST_MEM_WAIT : ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                cnt_n   = cnt - CW'(1);
                state_n = (cnt == CW'(1)) ? ST_RUN : ST_MEM_WAIT;
            end
            ST_HALTED: state_n = ST_HALTED;
            default:   state_n = ST_RUN;
        endcase
    end

    // a load writes back only in the last cycle of its memory access
    always_comb begin
        word_n  = NOP;
        stall_n = 1'b0;
        ill_n   = 1'b0;
        case (state)
            ST_RUN: begin
                word_n = go ? dec_word : NOP;
                if (go && dec_word.mem_read)
                    word_n.reg_write = (MEM_LAT == 1);
                stall_n = go & (dec_word.done | (is_mem & (MEM_LAT > 1)));
                ill_n   = go & dec_ill;
            end
            ST_MEM_WAIT: begin
                word_n           = word_q;
                word_n.reg_write = word_q.mem_read & (cnt == CW'(1));
                stall_n          = cnt > CW'(1);
            end
            ST_HALTED: begin
                word_n.done = 1'b1;
                stall_n     = 1'b1;
            end
            default: word_n = NOP;
        endcase
    end

    assign bus.alu_func      = word_q.alu_func;
    assign bus.alu_spec_func = word_q.spec_func;
    assign bus.reg_write_val = RSEL_W'(word_q.dest);
    assign bus.alu_src       = word_q.alu_src;
    assign bus.mem_write     = word_q.mem_write;
    assign bus.mem_read      = word_q.mem_read;
    assign bus.branch        = word_q.branch;
    assign bus.reg_write     = word_q.reg_write;
    assign bus.swap_ctrl     = word_q.swap;
    assign bus.jmp_ctrl      = word_q.jmp;
    assign bus.done_ctrl     = word_q.done;
    assign bus.pc_stall      = stall_q;
    assign bus.illegal       = ill_q;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: directed checks of decode, memory wait states, flush, halt and illegal trap (MEM_LAT=3)
module tb_control_unit_mc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_unit_mc_if #(.INSTR_W(9), .RSEL_W(3)) bus ();

    control_unit_mc #(.INSTR_W(9), .RSEL_W(3), .MEM_LAT(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // {alu_func, spec_func, dest, alu_src, mem_write, mem_read, branch, reg_write, swap, jmp, done, stall, illegal}
    logic [19:0] obs;
    assign obs = {bus.alu_func, bus.alu_spec_func, bus.reg_write_val, bus.alu_src, bus.mem_write,
                  bus.mem_read, bus.branch, bus.reg_write, bus.swap_ctrl, bus.jmp_ctrl,
                  bus.done_ctrl, bus.pc_stall, bus.illegal};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [8:0] ins, input logic v, input logic f);
        bus.instruction = ins;
        bus.instr_valid = v;
        bus.flush       = f;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(9'b0, 1'b0, 1'b0);
        tick();
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_init: got %h expected %h", obs, 20'h0); end
        checks++;
        reset = 1'b0;
        drive(9'b0001_01_000, 1'b1, 1'b0);
        tick();
        drive(9'b0000_10_000, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_mid_wait: got %h expected %h", obs, 20'h0); end
        checks++;
        reset = 1'b0;
        tick();
        if (obs !== {4'b0000, 3'b000, 3'b010, 10'b0000100000}) begin
            errors++; $display("FAIL reset_then_add: got %h expected %h", obs, {4'b0000, 3'b000, 3'b010, 10'b0000100000});
        end
        checks++;
        drive(9'b0, 1'b0, 1'b0);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_then_idle: got %h expected %h", obs, 20'h0); end
        checks++;
    endtask

    task automatic test_decode();
        logic [8:0]  ins [8] = '{9'b0000_10_000, 9'b0011_01_000, 9'b0110_00_101, 9'b1100_00_000,
                                 9'b1110_00_000, 9'b1001_00_000, 9'b0111_11_000, 9'b0111_00_100};
        logic [19:0] exp [8] = '{{4'b0000, 3'b000, 3'b010, 10'b0000100000},
                                 {4'b0011, 3'b000, 3'b001, 10'b0000100000},
                                 {4'b0110, 3'b000, 3'b101, 10'b0000100000},
                                 {4'b1100, 3'b000, 3'b000, 10'b0001000000},
                                 {4'b0000, 3'b000, 3'b000, 10'b0000001000},
                                 {4'b0000, 3'b000, 3'b000, 10'b0000010000},
                                 {4'b0111, 3'b000, 3'b011, 10'b0000100000},
                                 {4'b0111, 3'b100, 3'b000, 10'b0000100000}};
        for (int i = 0; i < 8; i++) begin
            drive(ins[i], 1'b1, 1'b0);
            tick();
            if (obs !== exp[i]) begin errors++; $display("FAIL decode_%0d: got %h expected %h", i, obs, exp[i]); end
            checks++;
        end
        drive(9'b0000_10_000, 1'b0, 1'b0);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL decode_invalid: got %h expected %h", obs, 20'h0); end
        checks++;
    endtask

    task automatic test_mem();
        logic [19:0] ld_exp [3] = '{{4'b0, 3'b0, 3'b001, 10'b0010000010},
                                    {4'b0, 3'b0, 3'b001, 10'b0010000010},
                                    {4'b0, 3'b0, 3'b001, 10'b0010100000}};
        logic [19:0] st_exp [3] = '{{4'b0, 3'b0, 3'b000, 10'b0100000010},
                                    {4'b0, 3'b0, 3'b000, 10'b0100000010},
                                    {4'b0, 3'b0, 3'b000, 10'b0100000000}};
        drive(9'b0001_01_000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs !== ld_exp[i]) begin errors++; $display("FAIL ld_cycle_%0d: got %h expected %h", i, obs, ld_exp[i]); end
            checks++;
            drive(9'b0000_10_000, 1'b1, 1'b1);
        end
        drive(9'b0000_10_000, 1'b1, 1'b0);
        tick();
        if (obs !== {4'b0000, 3'b000, 3'b010, 10'b0000100000}) begin
            errors++; $display("FAIL add_after_ld: got %h expected %h", obs, {4'b0000, 3'b000, 3'b010, 10'b0000100000});
        end
        checks++;
        drive(9'b0010_00_000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs !== st_exp[i]) begin errors++; $display("FAIL st_cycle_%0d: got %h expected %h", i, obs, st_exp[i]); end
            checks++;
            drive(9'b0111_00_010, 1'b1, 1'b0);
        end
        drive(9'b0, 1'b0, 1'b0);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL idle_after_st: got %h expected %h", obs, 20'h0); end
        checks++;
    endtask

    task automatic test_flush();
        drive(9'b1010_1_0000, 1'b1, 1'b1);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL stl_flushed: got %h expected %h", obs, 20'h0); end
        checks++;
        drive(9'b1010_1_0000, 1'b1, 1'b0);
        tick();
        if (obs !== {4'b1010, 3'b000, 3'b111, 10'b1000100000}) begin
            errors++; $display("FAIL stl: got %h expected %h", obs, {4'b1010, 3'b000, 3'b111, 10'b1000100000});
        end
        checks++;
        drive(9'b1011_0_0000, 1'b1, 1'b0);
        tick();
        if (obs !== {4'b1011, 3'b000, 3'b001, 10'b1000100000}) begin
            errors++; $display("FAIL sth: got %h expected %h", obs, {4'b1011, 3'b000, 3'b001, 10'b1000100000});
        end
        checks++;
    endtask

    task automatic test_halt();
        drive(9'b0111_00_010, 1'b1, 1'b1);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL hlt_flushed: got %h expected %h", obs, 20'h0); end
        checks++;
        drive(9'b0111_00_010, 1'b1, 1'b0);
        tick();
        drive(9'b0000_10_000, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (obs !== 20'b110) begin errors++; $display("FAIL halted_%0d: got %h expected %h", i, obs, 20'b110); end
            checks++;
            tick();
        end
        reset = 1'b1;
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL halt_reset: got %h expected %h", obs, 20'h0); end
        checks++;
        reset = 1'b0;
        tick();
        if (obs !== {4'b0000, 3'b000, 3'b010, 10'b0000100000}) begin
            errors++; $display("FAIL add_after_halt: got %h expected %h", obs, {4'b0000, 3'b000, 3'b010, 10'b0000100000});
        end
        checks++;
    endtask

    task automatic test_illegal();
        drive(9'b1111_00_000, 1'b1, 1'b0);
        tick();
        if (obs !== 20'h1) begin errors++; $display("FAIL illegal_1111: got %h expected %h", obs, 20'h1); end
        checks++;
        drive(9'b0, 1'b0, 1'b0);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL illegal_pulse: got %h expected %h", obs, 20'h0); end
        checks++;
        drive(9'b0111_00_101, 1'b1, 1'b0);
        tick();
        if (obs !== 20'h1) begin errors++; $display("FAIL illegal_spec101: got %h expected %h", obs, 20'h1); end
        checks++;
        drive(9'b1000_00_000, 1'b1, 1'b0);
        tick();
        if (obs !== 20'h1) begin errors++; $display("FAIL illegal_1000: got %h expected %h", obs, 20'h1); end
        checks++;
        drive(9'b1000_00_000, 1'b1, 1'b1);
        tick();
        if (obs !== 20'h0) begin errors++; $display("FAIL illegal_flushed: got %h expected %h", obs, 20'h0); end
        checks++;
    endtask

    task automatic test_back_to_back();
        drive(9'b0011_11_000, 1'b1, 1'b0);
        tick();
        drive(9'b1101_00_000, 1'b1, 1'b0);
        if (obs !== {4'b0011, 3'b000, 3'b011, 10'b0000100000}) begin
            errors++; $display("FAIL b2b_sl: got %h expected %h", obs, {4'b0011, 3'b000, 3'b011, 10'b0000100000});
        end
        checks++;
        tick();
        if (obs !== {4'b1101, 3'b000, 3'b000, 10'b0001000000}) begin
            errors++; $display("FAIL b2b_blt: got %h expected %h", obs, {4'b1101, 3'b000, 3'b000, 10'b0001000000});
        end
        checks++;
    endtask

    initial begin
        drive(9'b0, 1'b0, 1'b0);
        test_reset();
        test_decode();
        test_mem();
        test_flush();
        test_back_to_back();
        test_illegal();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
